// File: rtl/vga_sync_detector.sv
`timescale 1ns/1ps
// vga_sync_detector
//   Receive-side timing recovery for the VGA sync generator. Samples the
//   active-low HS/VS pair and rebuilds HCNT/VCNT so they carry the same count
//   as the generator. It also measures line and frame periods and reports
//   LOCKED once the timing has matched the expected parameters long enough.
//
// Ports
//   CLK          pixel clock
//   RST_N        asynchronous active-low reset
//   HS_IN        horizontal sync, active low, synchronous to CLK
//   VS_IN        vertical sync, active low; its edges coincide with HS falls
//   HCNT/VCNT    recovered horizontal / vertical count
//   HMEAS        last line period in CLK cycles (saturates at 1023)
//   VMEAS        last frame period in lines (saturates at 1023)
//   LOCKED       timing matches HPERIOD/VPERIOD
//   FRAME_START  one-cycle pulse while VCNT first reads 0 after a wrap
//   SYNC_ERR     one-cycle pulse on a period mismatch outside S_SEARCH
module vga_sync_detector #(
  parameter int HPERIOD    = 800,
  parameter int HFRONT     = 16,
  parameter int VPERIOD    = 525,
  parameter int VFRONT     = 10,
  parameter int LOCK_LINES = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       HS_IN,
  input  logic       VS_IN,
  output logic [9:0] HCNT,
  output logic [9:0] VCNT,
  output logic [9:0] HMEAS,
  output logic [9:0] VMEAS,
  output logic       LOCKED,
  output logic       FRAME_START,
  output logic       SYNC_ERR
);

  localparam logic [9:0] H_LAST   = 10'(HPERIOD - 1);
  localparam logic [9:0] V_LAST   = 10'(VPERIOD - 1);
  localparam logic [9:0] HPER     = 10'(HPERIOD);
  localparam logic [9:0] VPER     = 10'(VPERIOD);
  // HS falls while the generator shows HFRONT, so the next cycle is HFRONT+1.
  localparam logic [9:0] H_RELOAD = 10'(HFRONT + 1);
  localparam logic [9:0] V_RELOAD = 10'(VFRONT);
  localparam logic [9:0] SAT      = 10'h3FF;
  localparam logic [7:0] G_LAST   = 8'(LOCK_LINES - 1);

  typedef enum logic [1:0] {S_SEARCH, S_HLOCK, S_LOCKED} state_t;

  state_t     state_q, state_d;
  logic       hs_q, vs_q;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [9:0] hm_q, hm_d, hmeas_q, hmeas_d;
  logic [9:0] lm_q, lm_d, vmeas_q, vmeas_d;
  logic       hseen_q, hseen_d, vseen_q, vseen_d;
  logic [7:0] g_q, g_d;
  logic       locked_q, fs_q, fs_d, err_q, err_d;

  logic       hfall, vfall, hgood, vgood, hbad;
  logic [9:0] hm_inc, lm_inc;

  assign hfall  = hs_q & ~HS_IN;
  assign vfall  = vs_q & ~VS_IN;
  assign hm_inc = (hm_q == SAT) ? SAT : hm_q + 10'd1;
  assign lm_inc = (lm_q == SAT) ? SAT : lm_q + 10'd1;
  // hm_inc is the period that would be latched into HMEAS at this hfall.
  assign hgood  = hseen_q && (hm_inc == HPER);
  assign hbad   = hfall && !hgood;
  assign vgood  = vseen_q && (lm_q == VPER);

  // Counters and measurements
  always_comb begin
    hcnt_d  = (hcnt_q == H_LAST) ? 10'd0 : hcnt_q + 10'd1;
    vcnt_d  = vcnt_q;
    fs_d    = 1'b0;
    hm_d    = hm_inc;
    hmeas_d = hmeas_q;
    hseen_d = hseen_q | hfall;
    lm_d    = lm_q;
    vmeas_d = vmeas_q;
    vseen_d = vseen_q | vfall;

    if (hfall) begin
      hcnt_d = H_RELOAD;
      hm_d   = 10'd0;
      lm_d   = lm_inc;
      // The first edge after reset only starts the measurement.
      if (hseen_q) hmeas_d = hm_inc;
    end

    // VCNT aligns only when VS and HS fall together; a lone VS edge is
    // still measured below but never moves the count.
    if (hfall && vfall) begin
      vcnt_d = V_RELOAD;
    end else if (!hfall && hcnt_q == H_LAST) begin
      if (vcnt_q == V_LAST) begin
        vcnt_d = 10'd0;
        fs_d   = 1'b1;
      end else begin
        vcnt_d = vcnt_q + 10'd1;
      end
    end

    if (vfall) begin
      lm_d = 10'd1;
      if (vseen_q) vmeas_d = lm_q;
    end
  end

  // Lock state machine
  always_comb begin
    state_d = state_q;
    g_d     = 8'd0;
    err_d   = 1'b0;
    unique case (state_q)
      S_SEARCH: begin
        g_d = g_q;
        if (hfall && hseen_q) begin
          if (!hgood)             g_d = 8'd0;
          else if (g_q == G_LAST) state_d = S_HLOCK;
          else                    g_d = g_q + 8'd1;
        end
        if (state_d != S_SEARCH) g_d = 8'd0;
      end
      S_HLOCK: begin
        if (hbad) begin
          err_d   = 1'b1;
          state_d = S_SEARCH;
        end else if (vfall && vgood) begin
          state_d = S_LOCKED;
        end
      end
      S_LOCKED: begin
        // A saturated line counter means HS has gone missing.
        if (hbad || (vfall && !vgood) || (!hfall && hm_q == SAT)) begin
          err_d   = 1'b1;
          state_d = S_SEARCH;
        end
      end
      default: state_d = S_SEARCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_SEARCH;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      hm_q     <= '0;
      hmeas_q  <= '0;
      lm_q     <= '0;
      vmeas_q  <= '0;
      hseen_q  <= 1'b0;
      vseen_q  <= 1'b0;
      g_q      <= '0;
      locked_q <= 1'b0;
      fs_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hs_q     <= HS_IN;
      vs_q     <= VS_IN;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      hm_q     <= hm_d;
      hmeas_q  <= hmeas_d;
      lm_q     <= lm_d;
      vmeas_q  <= vmeas_d;
      hseen_q  <= hseen_d;
      vseen_q  <= vseen_d;
      g_q      <= g_d;
      // LOCKED follows the state one cycle late.
      locked_q <= (state_q == S_LOCKED);
      fs_q     <= fs_d;
      err_q    <= err_d;
    end
  end

  assign HCNT        = hcnt_q;
  assign VCNT        = vcnt_q;
  assign HMEAS       = hmeas_q;
  assign VMEAS       = vmeas_q;
  assign LOCKED      = locked_q;
  assign FRAME_START = fs_q;
  assign SYNC_ERR    = err_q;

endmodule

// File: doc/vga_sync_detector.md
Name: vga_sync_detector

Overview:
- Receive-side counterpart of the VGA sync generator: samples active-low VGA_HS/VGA_VS, all synchronous to CLK (pixel clock).
- Recovers HCNT/VCNT aligned to the generator's count convention.
- Measures line and frame periods and asserts LOCKED once timing matches the expected VGA 640x480 parameters.
- Used for loopback self-check of the video output path and as the timing front end for captured video.

Parameters:
- HPERIOD, 800, expected pixels per line.
- HFRONT, 16, generator HCNT value during the first cycle HS is low.
- VPERIOD, 525, expected lines per frame.
- VFRONT, 10, generator VCNT value during the line on which VS first goes low.
- LOCK_LINES, 4, consecutive good line periods required before vertical lock is attempted.

Ports:
- CLK  in  1  pixel clock.
- RST_N  in  1  asynchronous active-low reset.
- HS_IN  in  1  horizontal sync, active low, synchronous to CLK.
- VS_IN  in  1  vertical sync, active low, synchronous to CLK; edges coincide with HS falling edges.
- HCNT  out  10  recovered horizontal count.
- VCNT  out  10  recovered vertical count.
- HMEAS  out  10  last measured line period in CLK cycles, saturating at 1023.
- VMEAS  out  10  last measured frame period in lines, saturating at 1023.
- LOCKED  out  1  timing matches parameters.
- FRAME_START  out  1  one-cycle pulse when VCNT wraps to 0.
- SYNC_ERR  out  1  one-cycle pulse on any period mismatch while not in S_SEARCH.

Behaviour:
- Reset (RST_N=0, async): HCNT=0, VCNT=0, HMEAS=0, VMEAS=0, LOCKED=0, FRAME_START=0, SYNC_ERR=0, state S_SEARCH.
  - hs_q/vs_q input registers reset to 1; internal counters reset to 0.
  - Reset asserted mid-frame discards all measurements. Re-lock is needed from scratch.
- Edge detect:
  - hfall = hs_q & ~HS_IN, evaluated at a posedge; hs_q <= HS_IN every cycle.
  - vfall is defined the same way from vs_q and VS_IN.
- Horizontal counter:
  - On hfall: HCNT <= HFRONT+1. This matches the generator's count on the following cycle, so there is zero phase error.
  - Else if HCNT == HPERIOD-1: HCNT <= 0.
  - Else: HCNT <= HCNT+1.
  - Free-runs before the first edge.
- Line measurement: cycle counter hm counts cycles since the last hfall, saturating at 1023.
  - On hfall: HMEAS <= hm+1, saturating at 1023; then hm <= 0.
  - The first hfall after reset only restarts hm and does not update HMEAS.
- Vertical counter, advanced only in the cycle the horizontal count wraps or is reloaded past its end:
  - If hfall coincides with vfall: VCNT <= VFRONT.
  - Else if HCNT == HPERIOD-1 and no hfall: VCNT <= VCNT == VPERIOD-1 ? 0 : VCNT+1.
  - FRAME_START=1 for exactly the cycle after VCNT becomes 0.
- Frame measurement:
  - Line counter lm increments on each hfall, saturating at 1023.
  - On vfall: VMEAS <= lm, then lm <= 1. The first vfall after reset does not update VMEAS.
- State machine:
  - S_SEARCH: count consecutive hfalls with HMEAS == HPERIOD (good count g). A bad period clears g. When g reaches LOCK_LINES, go to S_HLOCK.
  - S_HLOCK: on each hfall, if HMEAS != HPERIOD, pulse SYNC_ERR and return to S_SEARCH with g=0. On vfall, if VMEAS == VPERIOD, go to S_LOCKED; otherwise stay in S_HLOCK (VMEAS not yet valid or wrong).
  - S_LOCKED: LOCKED=1 (registered, asserted the cycle after entry). A mismatch in HMEAS at hfall, or in VMEAS at vfall, pulses SYNC_ERR, drops LOCKED the next cycle, and goes to S_SEARCH.
  - S_LOCKED, missing HS: if hm saturates at 1023 with no hfall, treat it as a mismatch.
- Simultaneous hfall and HCNT == HPERIOD-1: hfall wins.
- VS edge without an HS edge in the same cycle: ignored for VCNT alignment, still measured.

Test Plan:
- Nominal loop from syncgen (800x525, HFRONT=16, VFRONT=10) after reset:
  - LOCKED rises during the 2nd frame.
  - HCNT/VCNT equal generator HCNT/VCNT every cycle after the first hfall and vfall.
  - HMEAS=800, VMEAS=525, one FRAME_START per 420000 cycles.
- Line stretched to 801 cycles once while locked → SYNC_ERR pulse at that hfall, LOCKED low next cycle, relock after 4 good lines plus a good frame.
- Frame of 524 lines while locked → SYNC_ERR at vfall with VMEAS=524, LOCKED drops.
- HS held high 2000 cycles → HMEAS saturates at 1023 on next hfall, LOCKED=0, HCNT free-runs 0..799 meanwhile.
- RST_N pulsed low mid-line (async, between clock edges) → all outputs 0 immediately, first post-reset hfall does not update HMEAS.
- Only 3 good lines followed by a 799-cycle line in S_SEARCH → no transition to S_HLOCK, no SYNC_ERR.
